muldiv_seq: RTL and testbench

// Iterative RV32M multiply/divide sequencer; executes in parallel with the ALU.
// It computes, in one bit-step per cycle, the ops the single-cycle ALU cannot: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_addsub.sv | 19 +
 rtl/muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_muldiv_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and the special-case rule for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CALC  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } muldiv_state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] value;
    } special_t;

    // Divide-by-zero and signed-overflow results, which RV32M defines without a trap.
    function automatic special_t special_result(input muldiv_op_t op,
                                                input logic [31:0] op1,
                                                input logic [31:0] op2);
        special_t   s;
        logic [2:0] ob;
        ob      = op;
        s.hit   = 1'b0;
        s.value = '0;
        if (ob[2]) begin
            if (op2 == 32'd0) begin
                s.hit   = 1'b1;
                s.value = ob[1] ? op1 : 32'hFFFF_FFFF;
            end else if (!ob[0] && op1 == 32'h8000_0000 && op2 == 32'hFFFF_FFFF) begin
                s.hit   = 1'b1;
                s.value = ob[1] ? 32'd0 : 32'h8000_0000;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor for one shift-add or restoring-divide step.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cb
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
    assign sum  = full[W-1:0];
    // carry out when adding, borrow (a < b) when subtracting
    assign cb   = sub ? ~full[W] : full[W];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one bit-step per cycle beside the ALU.
//
// state | meaning
// IDLE  | ready for a request
// SETUP | capture sign flags and operand magnitudes
// CALC  | WIDTH shift-add / restoring-divide steps
// FIXUP | apply result sign and special-case overrides
// DONE  | hold result until rsp_ready_i
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] req_op1_i,
    input  logic [WIDTH-1:0] req_op2_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q;
    logic [2:0]       op_bits;
    logic [WIDTH-1:0] op1_q, op2_q, m_q, hi_q, lo_q, result_q;
    logic             sign1_q, sign2_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, is_div, fast_hit;
    special_t         fast_s, late_s;
    logic             signed1, signed2, s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   as_a, as_b, as_sum;
    logic             as_cb;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix, result_fix;

    assign op_bits      = op_q;
    assign is_div       = op_bits[2];
    assign req_ready_o  = (state_q == IDLE) & ~flush_i & ~reset_i;
    assign accept       = req_valid_i & req_ready_o;
    assign rsp_valid_o  = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign rsp_result_o = result_q;

    assign fast_s   = special_result(muldiv_op_t'(req_op_i), req_op1_i, req_op2_i);
    assign fast_hit = FAST_ZERO && fast_s.hit;
    assign late_s   = special_result(op_q, op1_q, op2_q);

    assign signed1 = (op_q == MD_MULH) || (op_q == MD_MULHSU) || (op_q == MD_DIV) || (op_q == MD_REM);
    assign signed2 = (op_q == MD_MULH) || (op_q == MD_DIV) || (op_q == MD_REM);
    assign s1      = signed1 & op1_q[WIDTH-1];
    assign s2      = signed2 & op2_q[WIDTH-1];
    assign mag1    = s1 ? -op1_q : op1_q;
    assign mag2    = s2 ? -op2_q : op2_q;

    // Divide shifts the next dividend bit into the partial remainder; multiply adds into the high half.
    assign as_a = is_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    assign as_b = {1'b0, (is_div | lo_q[0]) ? m_q : {WIDTH{1'b0}}};

    muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (is_div),
        .sum (as_sum),
        .cb  (as_cb)
    );

    assign prod     = {hi_q, lo_q};
    assign prod_fix = (sign1_q ^ sign2_q) ? -prod : prod;
    assign q_fix    = (sign1_q ^ sign2_q) ? -lo_q : lo_q;
    assign r_fix    = sign1_q ? -hi_q : hi_q;

    always_comb begin
        result_fix = r_fix;
        case (op_q)
            MD_MUL:                       result_fix = prod_fix[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_fix = prod_fix[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              result_fix = q_fix;
            default:                      result_fix = r_fix;
        endcase
        if (late_s.hit) result_fix = late_s.value;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = fast_hit ? DONE : SETUP;
            SETUP: state_d = CALC;
            CALC:  if (cnt_q == '0) state_d = FIXUP;
            FIXUP: state_d = DONE;
            DONE:  if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q     <= MD_MUL;
            op1_q    <= '0;
            op2_q    <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q  <= muldiv_op_t'(req_op_i);
                    op1_q <= req_op1_i;
                    op2_q <= req_op2_i;
                    if (fast_hit) result_q <= fast_s.value;
                end
                SETUP: begin
                    sign1_q <= s1;
                    sign2_q <= s2;
                    hi_q    <= '0;
                    cnt_q   <= CW'(WIDTH - 1);
                    m_q     <= is_div ? mag2 : mag1;
                    lo_q    <= is_div ? mag1 : mag2;
                end
                CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div) begin
                        hi_q <= as_cb ? as_a[WIDTH-1:0] : as_sum[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], ~as_cb};
                    end else begin
                        hi_q <= as_sum[WIDTH:1];
                        lo_q <= {as_sum[0], lo_q[WIDTH-1:1]};
                    end
                end
                FIXUP: result_q <= result_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a plain-arithmetic RV32M reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i, flush_i, req_valid_i, rsp_ready_i;
    logic        req_ready_o, rsp_valid_o, busy_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_op1_i, req_op2_i, rsp_result_o;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq #(.WIDTH(32), .FAST_ZERO(1'b1)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      ub = {32'd0, b};
        logic [63:0] p;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 35;
    endfunction

    // Issue one request and wait (bounded) for the response; lat = cycles from accept edge, -1 on timeout.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = op; req_op1_i = a; req_op2_i = b;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = -1; busy_ok = 1'b1; res = 32'h0BAD_0BAD;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin lat = i; res = rsp_result_o; break; end
            if (!busy_o) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        req_op_i = 3'd0; req_op1_i = '0; req_op2_i = '0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid_o); end
        n_cmp++; if (rsp_result_o !== 32'd0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", rsp_result_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        reset_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got=%b exp=1", req_ready_o); end
    endtask

    task automatic test_mul_latency();
        logic [31:0] r; int lat; bit bok;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat, bok);
        n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL mul_latency got=%0d exp=35", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL mul_busy got=%b exp=1", bok); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] r; int lat; bit bok;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, bok);
            n_cmp++; if (r !== exp[i] || lat != 35) begin
                n_bad++; $display("FAIL mulh_%0d got=%h lat=%0d exp=%h lat=35", i, r, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r; int lat; bit bok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, bok);
            n_cmp++; if (r !== exp[i] || lat != 35) begin
                n_bad++; $display("FAIL div_%0d got=%h lat=%0d exp=%h lat=35", i, r, lat, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] r; int lat; bit bok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, bok);
            n_cmp++; if (r !== exp[i] || lat != 1) begin
                n_bad++; $display("FAIL special_%0d got=%h lat=%0d exp=%h lat=1", i, r, lat, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b, r; int lat; bit bok; int mode;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom; b = $urandom;
            mode = $urandom_range(0, 5);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 15));
            do_op(op, a, b, r, lat, bok);
            n_cmp++; if (r !== ref_result(op, a, b) || lat != ref_latency(op, a, b)) begin
                n_bad++; $display("FAIL random_%0d op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                                  i, op, a, b, r, lat, ref_result(op, a, b), ref_latency(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit seen; logic [31:0] r;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = 3'd5; req_op1_i = 32'd100; req_op2_i = 32'd7;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk_i); seen = rsp_valid_o; end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_first_valid got=0 exp=1"); end
        req_valid_i = 1'b1; req_op_i = 3'd5; req_op1_i = 32'd9; req_op2_i = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd14 || req_ready_o !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold_%0d valid=%b result=%h ready=%b exp valid=1 result=0000000e ready=0",
                                  i, rsp_valid_o, rsp_result_o, req_ready_o);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_after_handshake busy=%b ready=%b valid=%b exp busy=0 ready=1 valid=0",
                              busy_o, req_ready_o, rsp_valid_o);
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL bp_next_accept busy=%b exp=1", busy_o); end
        lat = -1; r = 32'h0BAD_0BAD;
        for (int i = 2; i <= 100; i++) begin
            if (rsp_valid_o) begin lat = i - 1; r = rsp_result_o; break; end
            @(negedge clk_i);
        end
        n_cmp++; if (r !== 32'd3 || lat != 35) begin
            n_bad++; $display("FAIL bp_next_result got=%h lat=%0d exp=00000003 lat=35", r, lat);
        end
    endtask

    task automatic test_flush(input bit use_reset);
        logic [31:0] r; int lat; bit bok; bit seen;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = 3'd1; req_op1_i = $urandom; req_op2_i = $urandom;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (11) @(negedge clk_i);
        if (use_reset) reset_i = 1'b1; else flush_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL kill_%0d_idle busy=%b ready=%b valid=%b exp busy=0 ready=1 valid=0",
                              use_reset, busy_o, req_ready_o, rsp_valid_o);
        end
        if (use_reset) begin
            n_cmp++; if (rsp_result_o !== 32'd0) begin
                n_bad++; $display("FAIL kill_reset_result got=%h exp=0", rsp_result_o);
            end
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk_i); seen |= rsp_valid_o; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL kill_%0d_no_rsp got=1 exp=0", use_reset); end
        do_op(3'd5, 32'd9, 32'd3, r, lat, bok);
        n_cmp++; if (r !== 32'd3 || lat != 35) begin
            n_bad++; $display("FAIL kill_%0d_followup got=%h lat=%0d exp=00000003 lat=35", use_reset, r, lat);
        end
    endtask

    task automatic test_flush_beats_accept();
        bit seen;
        @(negedge clk_i);
        flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 3'd0; req_op1_i = 32'd3; req_op2_i = 32'd3;
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_accept_ready got=%b exp=0", req_ready_o); end
        @(posedge clk_i); #1;
        flush_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk_i);
        seen = busy_o;
        repeat (40) begin @(negedge clk_i); seen |= rsp_valid_o | busy_o; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_accept_ignored got=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_div();
        test_special();
        test_random();
        test_back_to_back();
        test_flush(1'b0);
        test_flush(1'b1);
        test_flush_beats_accept();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
